// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage between fetch and execute.
// Combinational decode of the incoming word is captured into a main entry;
// an optional skid entry absorbs one extra word so in_ready can come from a flop.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit HAS_SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISCMEM  = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  entry_t dec, main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   fmt_i, fmt_s, fmt_b, fmt_u, fmt_j, fmt_r;
  logic [31:0]      imm32;
  logic [XLEN+31:0] imm_ext;
  logic   load_main, accept;

  // Format classification and field decode of the incoming word
  always_comb begin
    fmt_i = 1'b0; fmt_s = 1'b0; fmt_b = 1'b0;
    fmt_u = 1'b0; fmt_j = 1'b0; fmt_r = 1'b0;
    case (in_instr[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR,
      OP_SYSTEM, OP_MISCMEM: fmt_i = 1'b1;
      OP_STORE:              fmt_s = 1'b1;
      OP_BRANCH:             fmt_b = 1'b1;
      OP_LUI, OP_AUIPC:      fmt_u = 1'b1;
      OP_JAL:                fmt_j = 1'b1;
      OP_OP:                 fmt_r = 1'b1;
      OP_OPIMM32:            fmt_i = (XLEN == 64);
      OP_OP32:               fmt_r = (XLEN == 64);
      default: ;
    endcase

    // All format flags are zero for an illegal word, so imm and flags fall to zero
    imm32 = 32'h0;
    if (fmt_i) imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    if (fmt_s) imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    if (fmt_b) imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    if (fmt_u) imm32 = {in_instr[31:12], 12'h0};
    if (fmt_j) imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    imm_ext = {{XLEN{imm32[31]}}, imm32};

    dec          = '0;
    dec.instr    = in_instr;
    dec.pc       = in_pc;
    dec.imm      = imm_ext[XLEN-1:0];
    dec.illegal  = ~(fmt_i | fmt_s | fmt_b | fmt_u | fmt_j | fmt_r);
    // ecall/ebreak style SYSTEM words (funct3 = 0) have no rs1 source
    dec.rs1_used = (fmt_i & ~(in_instr[6:0] == OP_SYSTEM && in_instr[14:12] == 3'b000))
                 | fmt_s | fmt_b | fmt_r;
    dec.rs2_used = fmt_s | fmt_b | fmt_r;
    dec.rd_we    = ((fmt_i & (in_instr[6:0] != OP_MISCMEM)) | fmt_u | fmt_j | fmt_r)
                 & (in_instr[11:7] != 5'd0);
  end

  // Main entry can take a word when it is empty or handing its bundle off this edge
  assign load_main = ~main_valid | out_ready;
  assign in_ready  = HAS_SKID ? ~skid_valid : (out_ready | ~main_valid);
  assign accept    = in_valid & in_ready;

  // Two-entry buffer: skid refills main first, flush wins over any transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (HAS_SKID && accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign opcode    = main_q.instr[6:0];
  assign rd        = main_q.instr[11:7];
  assign funct3    = main_q.instr[14:12];
  assign rs1       = main_q.instr[19:15];
  assign rs2       = main_q.instr[24:20];
  assign funct7    = main_q.instr[31:25];
  assign imm       = main_q.imm;
  assign rs1_used  = main_q.rs1_used;
  assign rs2_used  = main_q.rs2_used;
  assign rd_we     = main_q.rd_we;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage (XLEN=32, skid enabled): directed decode vectors,
// backpressure, flush, async reset and a randomized stream against a queue model.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int BW   = 132;
  typedef logic [BW-1:0] bvec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        rs1u, rs2u, rdwe, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_pc, out_instr, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        rs1_used, rs2_used, rd_we, illegal;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  decode_stage #(.XLEN(XLEN), .HAS_SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode written from the format rules with shifts on a signed word
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    byte  f;
    int   s, sgn, hi;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: f = "I";
      7'h23: f = "S";
      7'h63: f = "B";
      7'h37, 7'h17: f = "U";
      7'h6F: f = "J";
      7'h33: f = "R";
      7'h1B: f = (XLEN == 64) ? "I" : "X";
      7'h3B: f = (XLEN == 64) ? "R" : "X";
      default: f = "X";
    endcase
    s   = ins;
    sgn = s >>> 31;
    e.instr = ins;
    e.pc    = pc;
    e.imm   = 32'h0;
    case (f)
      "I": e.imm = s >>> 20;
      "S": begin hi = s >>> 25; e.imm = (hi << 5) | ((ins >> 7) & 32'h1F); end
      "B": e.imm = (sgn << 12) | (((ins >> 7) & 32'h1) << 11)
                 | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      "U": e.imm = ins & 32'hFFFFF000;
      "J": e.imm = (sgn << 20) | (((ins >> 12) & 32'hFF) << 12)
                 | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      default: e.imm = 32'h0;
    endcase
    e.ill  = (f == "X");
    e.rs1u = (f == "I" || f == "S" || f == "B" || f == "R")
           && !(ins[6:0] == 7'h73 && ins[14:12] == 3'd0);
    e.rs2u = (f == "S" || f == "B" || f == "R");
    e.rdwe = (f == "I" || f == "U" || f == "J" || f == "R")
           && ins[6:0] != 7'h0F && ins[11:7] != 5'd0;
    return e;
  endfunction

  function automatic bvec_t act_vec();
    return {out_instr, out_pc, imm, rs1_used, rs2_used, rd_we, illegal,
            opcode, rd, funct3, rs1, rs2, funct7};
  endfunction

  function automatic bvec_t exp_vec(input exp_t e);
    return {e.instr, e.pc, e.imm, e.rs1u, e.rs2u, e.rdwe, e.ill,
            e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15],
            e.instr[24:20], e.instr[31:25]};
  endfunction

  // Sample handshakes just before the edge, then advance to the next falling edge
  task automatic tick(output bit acc, output bit dr);
    #1;
    acc = in_valid & in_ready & ~flush;
    dr  = out_valid & out_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++;
    if (act_vec() !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", act_vec()); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ins [12] = '{32'hFFF00093, 32'hFE112E23, 32'h001000EF, 32'h123452B7,
                              32'h00000000, 32'h0000001B, 32'h00000073, 32'h300110F3,
                              32'hFE208EE3, 32'h0FF0000F, 32'h002081B3, 32'h00001517};
    logic [31:0] ims [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h12345000,
                              32'h00000000, 32'h00000000, 32'h00000000, 32'h00000300,
                              32'hFFFFFFFC, 32'h000000FF, 32'h00000000, 32'h00001000};
    logic [3:0]  flg [12] = '{4'b1010, 4'b1100, 4'b0010, 4'b0010, 4'b0001, 4'b0001,
                              4'b0000, 4'b1010, 4'b1100, 4'b1000, 4'b1110, 4'b0010};
    bit acc, dr;
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_instr = ins[k]; in_pc = 32'h1000 + 32'(4 * k); out_ready = 1'b1;
      e = model(ins[k], in_pc);
      tick(acc, dr);
      in_valid = 1'b0;
      tests++;
      if (!acc || out_valid !== 1'b1) begin
        fails++; $display("FAIL dir_latency[%0d]: got acc=%b vld=%b want 1 1", k, acc, out_valid);
      end
      tests++;
      if (imm !== ims[k] || {rs1_used, rs2_used, rd_we, illegal} !== flg[k]) begin
        fails++; $display("FAIL dir_fields[%0d]: got imm=%h flags=%b want imm=%h flags=%b",
                          k, imm, {rs1_used, rs2_used, rd_we, illegal}, ims[k], flg[k]);
      end
      tests++;
      if (act_vec() !== exp_vec(e)) begin
        fails++; $display("FAIL dir_bundle[%0d]: got %h want %h", k, act_vec(), exp_vec(e));
      end
      tick(acc, dr);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL dir_drain[%0d]: got vld=%b want 0", k, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    bit acc, dr;
    int idx = 0, drains = 0, first = -1, last = -1;
    q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        tests++;
        if (q.size() == 0 || act_vec() !== exp_vec(q[0])) begin
          fails++; $display("FAIL bp_order: got %h want %h", act_vec(),
                            q.size() ? exp_vec(q[0]) : bvec_t'(0));
        end
      end
      in_valid = (idx < 8);
      in_instr = {$urandom_range(0, 32'h1FFFFFF), 7'h13};
      in_pc    = 32'h2000 + 32'(4 * idx);
      out_ready = (cyc >= 3);
      if (cyc == 2) begin
        tests++;
        if (in_ready !== 1'b0 || idx != 2) begin
          fails++; $display("FAIL bp_ready_drop: got rdy=%b accepts=%0d want rdy=0 accepts=2", in_ready, idx);
        end
      end
      tick(acc, dr);
      if (dr) begin
        if (q.size() != 0) void'(q.pop_front());
        drains++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (acc) begin q.push_back(model(in_instr, in_pc)); idx++; end
    end
    tests++;
    if (drains != 8 || last - first != 7) begin
      fails++; $display("FAIL bp_rate: got drains=%0d span=%0d want 8 and 7", drains, last - first);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    bit acc, dr;
    exp_t e;
    q.delete();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_instr = 32'h00500093 + (32'(k) << 20); in_pc = 32'h3000 + 32'(4 * k);
      tick(acc, dr);
    end
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL flush_fill: got rdy=%b vld=%b want 0 1", in_ready, out_valid);
    end
    flush = 1'b1; in_instr = 32'h00700093;
    tick(acc, dr);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_both: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    // Word offered while ready on a flush edge must be dropped
    tick(acc, dr);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(acc, dr);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop[%0d]: got vld=%b want 0", k, out_valid); end
    end
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_pc = 32'h3100;
    e = model(in_instr, in_pc);
    tick(acc, dr);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || act_vec() !== exp_vec(e)) begin
      fails++; $display("FAIL flush_recover: got vld=%b %h want 1 %h", out_valid, act_vec(), exp_vec(e));
    end
    tick(acc, dr);
  endtask

  task automatic test_random();
    bit acc, dr;
    logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h0B};
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      tests++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        fails++; $display("FAIL rand_occupancy: got vld=%b rdy=%b want entries=%0d", out_valid, in_ready, q.size());
      end
      if (out_valid && q.size() != 0) begin
        tests++;
        if (act_vec() !== exp_vec(q[0])) begin
          fails++; $display("FAIL rand_bundle: got %h want %h", act_vec(), exp_vec(q[0]));
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_pc     = $urandom;
      if ($urandom_range(0, 3) == 0) in_instr = $urandom;
      else in_instr = {$urandom_range(0, 32'h1FFFFFF), ops[$urandom_range(0, 13)]};
      tick(acc, dr);
      if (flush) q.delete();
      else begin
        if (dr && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back(model(in_instr, in_pc));
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit acc, dr;
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h123452B7; in_pc = 32'h4000;
    tick(acc, dr);
    tick(acc, dr);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || act_vec() !== '0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset: got vld=%b rdy=%b data=%h want 0 1 0", out_valid, in_ready, act_vec());
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    tick(acc, dr);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
